// File: rtl/cnn_stream_pkg.sv
// -----------------------------------------------------------------------------
// cnn_stream_pkg
// Shared definitions for the CNN frame streamer:
//   - state_e      : streamer FSM state encoding (IDLE, PRIME, STREAM, DONE)
//   - addr_width() : frame RAM address width for a w x h frame
//   - out_dim()    : emitted stream dimension, with or without the zero border
//   - cnt_width()  : width of a counter spanning 0..n-1
// No ports (package).
// -----------------------------------------------------------------------------
package cnn_stream_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_e;

   function automatic int addr_width(input int w, input int h);
      return (w * h > 1) ? $clog2(w * h) : 1;
   endfunction

   // A one-pixel zero border adds a row/column on each side.
   function automatic int out_dim(input int n, input bit pad_en);
      return pad_en ? n + 2 : n;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnn_frame_streamer_frame_ram.sv
// -----------------------------------------------------------------------------
// frame_ram
// Simple dual-port frame store: DEPTH words of DATA_W bits.
// The array has no reset so a loaded frame survives reset.
// Ports:
//   clk        : clock
//   wr_en_i    : host write strobe
//   wr_addr_i  : host write address
//   wr_data_i  : host write data
//   rd_en_i    : read enable; rd_data_o holds its value while low
//   rd_addr_i  : read address
//   rd_data_o  : registered read data (one cycle after rd_en_i)
// -----------------------------------------------------------------------------
module frame_ram
   import cnn_stream_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int AW     = 6
) (
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [AW-1:0]            wr_addr_i,
   input  logic signed [DATA_W-1:0] wr_data_i,
   input  logic                     rd_en_i,
   input  logic [AW-1:0]            rd_addr_i,
   output logic signed [DATA_W-1:0] rd_data_o
);

   logic signed [DATA_W-1:0] mem_q [DEPTH];
   logic signed [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cnn_frame_streamer.sv
// -----------------------------------------------------------------------------
// cnn_frame_streamer
// Frame-buffered raster pixel source for the CNN pipeline. The host loads one
// IMG_W x IMG_H frame while idle; on start the frame is streamed one pixel per
// cycle, with pause stalling the stream without skipping or repeating pixels.
//
// Build option: define CNN_STREAMER_ZERO_PAD_EN to wrap the frame in a
// one-pixel zero border (OUT_W = IMG_W+2, OUT_H = IMG_H+2); border pixels are
// produced without a RAM read.
//
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset
//   wr_en      : host write strobe (honoured only in IDLE)
//   wr_addr    : pixel address row*IMG_W+col
//   wr_data    : signed pixel value
//   wr_err     : one-cycle pulse, a write arrived while busy and was dropped
//   start      : begin streaming (level, acted on only in IDLE)
//   pause      : stall; no pixel emitted in the cycle after pause is sampled
//   busy       : frame in progress
//   done       : one-cycle pulse after the last pixel
//   out_valid  : pixel_out valid
//   pixel_out  : signed pixel, holds while out_valid is low
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | host may write; waits for start
// PRIME  | first RAM read in flight (held while pause is high)
// STREAM | one pixel per unpaused cycle, raster order
// DONE   | last pixel on the output; done pulses next cycle
// -----------------------------------------------------------------------------
module cnn_frame_streamer
   import cnn_stream_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   wr_en,
   input  logic [addr_width(IMG_W, IMG_H)-1:0]    wr_addr,
   input  logic signed [DATA_W-1:0]               wr_data,
   output logic                                   wr_err,
   input  logic                                   start,
   input  logic                                   pause,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   out_valid,
   output logic signed [DATA_W-1:0]               pixel_out
);

`ifdef CNN_STREAMER_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   localparam int OUT_W   = out_dim(IMG_W, PAD_EN);
   localparam int OUT_H   = out_dim(IMG_H, PAD_EN);
   localparam int AW      = addr_width(IMG_W, IMG_H);
   localparam int CW      = cnt_width(OUT_W);
   localparam int RW      = cnt_width(OUT_H);
   localparam int PAD_OFS = PAD_EN ? 1 : 0;

   localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);

   state_e                   state_q, state_d;
   logic [CW-1:0]            col_q, col_d, col_nxt;
   logic [RW-1:0]            row_q, row_d, row_nxt;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] pixel_out_q, pixel_out_d;
   logic                     done_q, done_d;
   logic                     wr_err_q, wr_err_d;

   logic                     emit;
   logic                     last_pix;
   logic                     ram_rd_en;
   logic [AW-1:0]            ram_rd_addr;
   logic signed [DATA_W-1:0] ram_rd_data;

   function automatic logic is_border(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return PAD_EN && ((r == '0) || (r == ROW_MAX) || (c == '0) || (c == COL_MAX));
   endfunction

   // Border positions give a meaningless address; they are never read.
   function automatic logic [AW-1:0] pix_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return AW'((int'(r) - PAD_OFS) * IMG_W + (int'(c) - PAD_OFS));
   endfunction

   assign emit     = (state_q == STREAM) && !pause;
   assign last_pix = (row_q == ROW_MAX) && (col_q == COL_MAX);

   always_comb begin
      col_nxt = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
      row_nxt = row_q;
      if (col_q == COL_MAX) begin
         row_nxt = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end
   end

   // The RAM register always holds the pending pixel: PRIME fetches the first
   // one, and each emit fetches the one after it. Pause simply stops reading.
   assign ram_rd_en   = ((state_q == PRIME) && !is_border(row_q, col_q)) ||
                        (emit && !last_pix && !is_border(row_nxt, col_nxt));
   assign ram_rd_addr = emit ? pix_addr(row_nxt, col_nxt) : pix_addr(row_q, col_q);

   frame_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W * IMG_H),
      .AW     (AW)
   ) u_frame_ram (
      .clk       (clk),
      .wr_en_i   (wr_en && (state_q == IDLE)),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_en_i   (ram_rd_en),
      .rd_addr_i (ram_rd_addr),
      .rd_data_o (ram_rd_data)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = PRIME;
         PRIME:   if (!pause) state_d = STREAM;
         STREAM:  if (emit && last_pix) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      out_valid_d = emit;
      pixel_out_d = pixel_out_q;
      done_d      = (state_q == DONE);
      wr_err_d    = wr_en && (state_q != IDLE);
      if (state_q == IDLE) begin
         col_d = '0;
         row_d = '0;
      end else if (emit) begin
         col_d       = col_nxt;
         row_d       = row_nxt;
         pixel_out_d = is_border(row_q, col_q) ? '0 : ram_rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         pixel_out_q <= '0;
         done_q      <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         pixel_out_q <= pixel_out_d;
         done_q      <= done_d;
         wr_err_q    <= wr_err_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign wr_err    = wr_err_q;
   assign out_valid = out_valid_q;
   assign pixel_out = pixel_out_q;

endmodule
